// File: rtl/frogger_game_fsm.sv
// Frogger game controller: lives, score, level and the
// start/respawn/play/dying/level-up/pause/game-over sequencing.
module frogger_game_fsm #(
   parameter int c_LIVES           = 3,
   parameter int c_GOALS_PER_LEVEL = 5,
   parameter int c_DEATH_TICKS     = 60,
   parameter int c_LEVEL_TICKS     = 90
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Start,
   input  logic       i_Pause,
   input  logic       i_Frame_Tick,
   input  logic       i_Collided,
   input  logic       i_Drowned,
   input  logic       i_Goal,
   output logic       o_Game_Active,
   output logic       o_Respawn,
   output logic       o_Death_Anim,
   output logic       o_Game_Over,
   output logic [2:0] o_State,
   output logic [1:0] o_Lives,
   output logic [6:0] o_Score,
   output logic [2:0] o_Level
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RESPAWN   = 3'd1;
   localparam logic [2:0] S_PLAY      = 3'd2;
   localparam logic [2:0] S_DYING     = 3'd3;
   localparam logic [2:0] S_LEVEL_UP  = 3'd4;
   localparam logic [2:0] S_PAUSED    = 3'd5;
   localparam logic [2:0] S_GAME_OVER = 3'd6;

   localparam int c_TICK_MAX = (c_DEATH_TICKS > c_LEVEL_TICKS) ? c_DEATH_TICKS : c_LEVEL_TICKS;
   localparam int c_TICK_W   = $clog2(c_TICK_MAX + 1);
   localparam int c_GOAL_W   = $clog2(c_GOALS_PER_LEVEL + 1);

   localparam logic [c_TICK_W-1:0] c_DEATH_LAST = c_TICK_W'(c_DEATH_TICKS - 1);
   localparam logic [c_TICK_W-1:0] c_LEVEL_LAST = c_TICK_W'(c_LEVEL_TICKS - 1);
   localparam logic [c_GOAL_W-1:0] c_GOAL_LAST  = c_GOAL_W'(c_GOALS_PER_LEVEL - 1);

   logic [2:0]          state, state_nxt;
   logic                start_q, pause_q;
   logic                start_edge, pause_edge;
   logic [1:0]          lives_nxt;
   logic [6:0]          score_nxt;
   logic [2:0]          level_nxt;
   logic [c_GOAL_W-1:0] goal_cnt, goal_nxt;
   logic [c_TICK_W-1:0] tick_cnt, tick_nxt;

   function automatic logic [6:0] sat_inc_score(input logic [6:0] v);
      return (v == 7'd127) ? v : v + 7'd1;
   endfunction

   function automatic logic [2:0] sat_inc_level(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   function automatic logic [1:0] sat_dec_lives(input logic [1:0] v);
      return (v == 2'd0) ? v : v - 2'd1;
   endfunction

   assign start_edge = i_Start & ~start_q;
   assign pause_edge = i_Pause & ~pause_q;
   assign o_State    = state;

   always_comb begin
      state_nxt = state;
      lives_nxt = o_Lives;
      score_nxt = o_Score;
      level_nxt = o_Level;
      goal_nxt  = goal_cnt;
      tick_nxt  = tick_cnt;
      case (state)
         S_IDLE: begin
            if (start_edge) begin
               lives_nxt = 2'(c_LIVES);
               score_nxt = '0;
               level_nxt = '0;
               goal_nxt  = '0;
               state_nxt = S_RESPAWN;
            end
         end
         S_RESPAWN: state_nxt = S_PLAY;
         S_PLAY: begin
            // Death outranks a goal arriving in the same cycle, which outranks pause.
            if (i_Collided | i_Drowned) begin
               lives_nxt = sat_dec_lives(o_Lives);
               tick_nxt  = '0;
               state_nxt = S_DYING;
            end else if (i_Goal) begin
               score_nxt = sat_inc_score(o_Score);
               if (goal_cnt == c_GOAL_LAST) begin
                  goal_nxt  = '0;
                  level_nxt = sat_inc_level(o_Level);
                  tick_nxt  = '0;
                  state_nxt = S_LEVEL_UP;
               end else begin
                  goal_nxt  = goal_cnt + c_GOAL_W'(1);
                  state_nxt = S_RESPAWN;
               end
            end else if (pause_edge) begin
               state_nxt = S_PAUSED;
            end
         end
         S_DYING: begin
            if (i_Frame_Tick) begin
               if (tick_cnt == c_DEATH_LAST)
                  state_nxt = (o_Lives == 2'd0) ? S_GAME_OVER : S_RESPAWN;
               else
                  tick_nxt = tick_cnt + c_TICK_W'(1);
            end
         end
         S_LEVEL_UP: begin
            if (i_Frame_Tick) begin
               if (tick_cnt == c_LEVEL_LAST)
                  state_nxt = S_RESPAWN;
               else
                  tick_nxt = tick_cnt + c_TICK_W'(1);
            end
         end
         S_PAUSED: begin
            if (pause_edge)
               state_nxt = S_PLAY;
         end
         S_GAME_OVER: begin
            if (start_edge)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status flags are decoded from the next state so they change with the state register.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state         <= S_IDLE;
         start_q       <= 1'b0;
         pause_q       <= 1'b0;
         o_Lives       <= '0;
         o_Score       <= '0;
         o_Level       <= '0;
         goal_cnt      <= '0;
         tick_cnt      <= '0;
         o_Game_Active <= 1'b0;
         o_Respawn     <= 1'b0;
         o_Death_Anim  <= 1'b0;
         o_Game_Over   <= 1'b0;
      end else begin
         state         <= state_nxt;
         start_q       <= i_Start;
         pause_q       <= i_Pause;
         o_Lives       <= lives_nxt;
         o_Score       <= score_nxt;
         o_Level       <= level_nxt;
         goal_cnt      <= goal_nxt;
         tick_cnt      <= tick_nxt;
         o_Game_Active <= (state_nxt == S_PLAY);
         o_Respawn     <= (state_nxt == S_RESPAWN);
         o_Death_Anim  <= (state_nxt == S_DYING);
         o_Game_Over   <= (state_nxt == S_GAME_OVER);
      end
   end

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Randomized and directed bench for frogger_game_fsm against a
// behavioural game model.
module tb_frogger_game_fsm;
   localparam int LIVES = 3, GPL = 5, DT = 60, LT = 90;

   logic       clk = 1'b0;
   logic       rst = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
   logic       col = 1'b0, drn = 1'b0, goal = 1'b0;
   logic       game_active, respawn, death_anim, game_over;
   logic [2:0] state;
   logic [1:0] lives;
   logic [6:0] score;
   logic [2:0] level;

   frogger_game_fsm #(
      .c_LIVES(LIVES), .c_GOALS_PER_LEVEL(GPL),
      .c_DEATH_TICKS(DT), .c_LEVEL_TICKS(LT)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Pause(pause),
      .i_Frame_Tick(tick), .i_Collided(col), .i_Drowned(drn), .i_Goal(goal),
      .o_Game_Active(game_active), .o_Respawn(respawn),
      .o_Death_Anim(death_anim), .o_Game_Over(game_over),
      .o_State(state), .o_Lives(lives), .o_Score(score), .o_Level(level)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   // model: 0 idle,1 respawn,2 play,3 dying,4 level-up,5 paused,6 game over
   int m_state = 0, m_lives = 0, m_score = 0, m_level = 0;
   int m_goals = 0, m_ticks = 0;
   bit m_sp = 0, m_pp = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, s, p, t, c, d, g);
      bit se, pe;
      se = s && !m_sp;
      pe = p && !m_pp;
      if (r) begin
         m_state = 0; m_lives = 0; m_score = 0; m_level = 0;
         m_goals = 0; m_ticks = 0; m_sp = 0; m_pp = 0;
         return;
      end
      if (m_state == 0) begin
         if (se) begin
            m_lives = LIVES; m_score = 0; m_level = 0; m_goals = 0; m_state = 1;
         end
      end else if (m_state == 1) begin
         m_state = 2;
      end else if (m_state == 2) begin
         if (c || d) begin
            if (m_lives > 0) m_lives = m_lives - 1;
            m_ticks = 0;
            m_state = 3;
         end else if (g) begin
            if (m_score < 127) m_score++;
            m_goals++;
            if (m_goals == GPL) begin
               m_goals = 0;
               if (m_level < 7) m_level++;
               m_ticks = 0;
               m_state = 4;
            end else m_state = 1;
         end else if (pe) m_state = 5;
      end else if (m_state == 3 || m_state == 4) begin
         if (t) begin
            m_ticks++;
            if (m_ticks == ((m_state == 3) ? DT : LT))
               m_state = (m_state == 4) ? 1 : ((m_lives == 0) ? 6 : 1);
         end
      end else if (m_state == 5) begin
         if (pe) m_state = 2;
      end else if (m_state == 6) begin
         if (se) m_state = 0;
      end
      m_sp = s;
      m_pp = p;
   endtask

   task automatic cycle(input bit r, s, p, t, c, d, g);
      @(negedge clk);
      rst = r; start = s; pause = p; tick = t; col = c; drn = d; goal = g;
      @(posedge clk);
      model_step(r, s, p, t, c, d, g);
      #1;
      chk("state", 32'(state), 32'(m_state));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("score", 32'(score), 32'(m_score));
      chk("level", 32'(level), 32'(m_level));
      chk("flags", {28'd0, game_active, respawn, death_anim, game_over},
          {28'd0, m_state == 2, m_state == 1, m_state == 3, m_state == 6});
   endtask

   task automatic idle_n(input int n, input bit t);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, t, 0, 0, 0);
   endtask

   initial begin
      bit p_lvl;
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
      chk("rst_state", 32'(state), 0);
      chk("rst_flags", {28'd0, game_active, respawn, death_anim, game_over}, 0);

      // start
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("start_respawn", 32'(respawn), 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("start_play", 32'(state), 2);
      chk("start_lives", 32'(lives), 3);
      chk("start_active", 32'(game_active), 1);

      // collide and goal together: death wins
      cycle(0, 0, 0, 0, 1, 0, 1);
      chk("prio_score", 32'(score), 0);
      chk("prio_lives", 32'(lives), 2);
      chk("prio_anim", 32'(death_anim), 1);
      idle_n(DT - 1, 1);
      chk("dying_hold", 32'(state), 3);
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("dying_end", 32'(respawn), 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("dying_play", 32'(state), 2);

      // pause ignores goals and ticks
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("paused", 32'(state), 5);
      for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, i[0], 0, 1);
      chk("paused_score", 32'(score), 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("unpaused", 32'(state), 2);

      // five goals -> level up, held LT ticks
      for (int i = 0; i < GPL; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 1);
         if (i < GPL - 1) cycle(0, 0, 0, 0, 0, 0, 0);
      end
      chk("lvl_state", 32'(state), 4);
      chk("lvl_score", 32'(score), 5);
      chk("lvl_level", 32'(level), 1);
      idle_n(LT - 1, 1);
      chk("lvl_hold", 32'(state), 4);
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("lvl_respawn", 32'(state), 1);
      cycle(0, 0, 0, 0, 0, 0, 0);

      // reset mid-dying
      cycle(0, 0, 0, 0, 0, 1, 0);
      idle_n(5, 1);
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk("rst_dying_state", 32'(state), 0);
      chk("rst_dying_vals", {22'd0, lives, score, level}, 0);
      chk("rst_dying_flags", {28'd0, game_active, respawn, death_anim, game_over}, 0);

      // three deaths -> game over, then restart
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < LIVES; k++) begin
         cycle(0, 0, 0, 0, 1, 0, 0);
         idle_n(DT, 1);
         if (k < LIVES - 1) cycle(0, 0, 0, 0, 0, 0, 0);
      end
      chk("go_flag", 32'(game_over), 1);
      chk("go_lives", 32'(lives), 0);
      idle_n(3, 1);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("go_idle", 32'(state), 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("restart_lives", 32'(lives), 3);
      chk("restart_score", 32'(score), 0);
      cycle(0, 0, 0, 0, 0, 0, 0);

      // score saturation at 127, level at 7
      for (int i = 0; i < 130; i++) begin
         cycle(0, 0, 0, 1, 0, 0, 1);
         for (int w = 0; w < 200 && m_state != 2; w++) cycle(0, 0, 0, 1, 0, 0, 0);
         chk("sat_play", 32'(state), 2);
      end
      chk("score_sat", 32'(score), 127);
      chk("level_sat", 32'(level), 7);

      // randomized run
      p_lvl = 0;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 15) == 0) p_lvl = !p_lvl;
         cycle($urandom_range(0, 999) == 0, $urandom_range(0, 19) == 0, p_lvl,
               $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
               $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
